// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: FSM states, access size encoding,
// data RAM depth helper and the MEM->WB payload record.
package mem_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        SIZE_BYTE = 1'b0,
        SIZE_WORD = 1'b1
    } size_t;

    // Data RAM depth in bytes for a given address width.
    function automatic int unsigned ram_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    typedef struct packed {
        logic        rf_enable;
        logic [3:0]  rd;
        logic [31:0] data;
        logic        align_err;
    } wb_payload_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX_MEM request / MEM_WB result bundle of the MEM stage.
// master = pipeline side driving the request, slave = the MEM stage.
interface mem_stage_if;
    logic        MEM_load_store_instr;
    logic        MEM_load_instr;
    logic        MEM_size;
    logic        MEM_RF_enable;
    logic [3:0]  MEM_rd;
    logic [31:0] MEM_alu_result;
    logic [31:0] MEM_store_data;
    logic        mem_stall;
    logic        WB_RF_enable;
    logic [3:0]  WB_rd;
    logic [31:0] WB_data;
    logic        align_err;

    modport master (
        output MEM_load_store_instr, MEM_load_instr, MEM_size, MEM_RF_enable,
               MEM_rd, MEM_alu_result, MEM_store_data,
        input  mem_stall, WB_RF_enable, WB_rd, WB_data, align_err
    );

    modport slave (
        input  MEM_load_store_instr, MEM_load_instr, MEM_size, MEM_RF_enable,
               MEM_rd, MEM_alu_result, MEM_store_data,
        output mem_stall, WB_RF_enable, WB_rd, WB_data, align_err
    );
endinterface

// File: rtl/mem_stage_dmem_ram.sv
// Byte-addressed big-endian data RAM: combinational byte/word read,
// synchronous byte/word write. Word lanes wrap modulo the RAM depth.
// Contents are not reset.
module dmem_ram
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  size_t             size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int unsigned DEPTH = ram_depth(ADDR_W);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] addr1, addr2, addr3;

    // Following byte lanes of a word, wrapping at the top of the RAM.
    always_comb begin
        addr1 = addr + ADDR_W'(1);
        addr2 = addr + ADDR_W'(2);
        addr3 = addr + ADDR_W'(3);
    end

    // Big-endian read: lowest address holds the most significant byte.
    always_comb begin
        if (size == SIZE_WORD) begin
            rdata = {mem_q[addr], mem_q[addr1], mem_q[addr2], mem_q[addr3]};
        end else begin
            rdata = {24'b0, mem_q[addr]};
        end
    end

    // Write port: one byte, or four big-endian bytes.
    always_ff @(posedge clk) begin
        if (we) begin
            if (size == SIZE_WORD) begin
                mem_q[addr]  <= wdata[31:24];
                mem_q[addr1] <= wdata[23:16];
                mem_q[addr2] <= wdata[15:8];
                mem_q[addr3] <= wdata[7:0];
            end else begin
                mem_q[addr]  <= wdata[7:0];
            end
        end
    end
endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage ARM pipeline: byte/word loads and stores on a
// big-endian data RAM with WAIT_STATES stall cycles per access, stall
// generation for upstream stages, and the registered MEM->WB payload.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned word accesses are
// suppressed and flagged on align_err; otherwise they wrap byte-by-byte.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        Reset,
    mem_stage_if.slave  bus
);
    localparam logic       HAS_WAIT = (WAIT_STATES != 0);
    localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state_d, state_q;
    logic [3:0]        cnt_d, cnt_q;
    wb_payload_t       wb_d, wb_q;
    logic              stall;
    logic              complete;
    logic              misalign;
    logic              ram_we;
    size_t             size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       rdata;

    assign size = size_t'(bus.MEM_size);
    assign addr = bus.MEM_alu_result[ADDR_W-1:0];

    // Misaligned word detection (only when alignment checking is built in).
    always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
        misalign = (size == SIZE_WORD) && (addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
    end

    // Wait-state sequencing: stall while counting, complete on the final cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.MEM_load_store_instr) begin
                    if (HAS_WAIT) begin
                        stall   = 1'b1;
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM write only on the completion edge of an allowed store.
    assign ram_we = complete && !bus.MEM_load_instr && !misalign && !Reset;

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_dmem_ram (
        .clk   (clk),
        .we    (ram_we),
        .size  (size),
        .addr  (addr),
        .wdata (bus.MEM_store_data),
        .rdata (rdata)
    );

    // Next WB payload: bubble while stalled, load data / pass-through otherwise.
    always_comb begin
        wb_d.rf_enable = 1'b0;
        wb_d.rd        = bus.MEM_rd;
        wb_d.data      = bus.MEM_alu_result;
        wb_d.align_err = 1'b0;
        if (stall) begin
            wb_d.rf_enable = 1'b0;
        end else if (complete) begin
            if (misalign) begin
                wb_d.data      = '0;
                wb_d.align_err = 1'b1;
            end else if (bus.MEM_load_instr) begin
                wb_d.data      = rdata;
                wb_d.rf_enable = bus.MEM_RF_enable;
            end
        end else begin
            wb_d.rf_enable = bus.MEM_RF_enable;
        end
    end

    // State, counter and WB registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
        end
    end

    assign bus.mem_stall    = stall && !Reset;
    assign bus.WB_RF_enable = wb_q.rf_enable;
    assign bus.WB_rd        = wb_q.rd;
    assign bus.WB_data      = wb_q.data;
    assign bus.align_err    = wb_q.align_err;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: one instance with no wait states and one
// with three. Stimulus pushes the expected WB payload; per-instance monitors
// pop and compare whenever WB_RF_enable or align_err is presented.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    mem_stage_if bus0();
    mem_stage_if bus3();

    logic        s_sel;
    logic        s_req, s_load, s_size, s_rfen;
    logic [3:0]  s_rd;
    logic [31:0] s_alu, s_sd;

    assign bus0.MEM_load_store_instr = s_req & ~s_sel;
    assign bus0.MEM_RF_enable        = s_rfen & ~s_sel;
    assign bus0.MEM_load_instr       = s_load;
    assign bus0.MEM_size             = s_size;
    assign bus0.MEM_rd               = s_rd;
    assign bus0.MEM_alu_result       = s_alu;
    assign bus0.MEM_store_data       = s_sd;

    assign bus3.MEM_load_store_instr = s_req & s_sel;
    assign bus3.MEM_RF_enable        = s_rfen & s_sel;
    assign bus3.MEM_load_instr       = s_load;
    assign bus3.MEM_size             = s_size;
    assign bus3.MEM_rd               = s_rd;
    assign bus3.MEM_alu_result       = s_alu;
    assign bus3.MEM_store_data       = s_sd;

    mem_stage #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (.clk(clk), .Reset(Reset), .bus(bus0));
    mem_stage #(.ADDR_W(8), .WAIT_STATES(3)) u_dut3 (.clk(clk), .Reset(Reset), .bus(bus3));

    logic stall_sel, wb_out_sel, wb_en_sel;
    assign stall_sel  = s_sel ? bus3.mem_stall : bus0.mem_stall;
    assign wb_en_sel  = s_sel ? bus3.WB_RF_enable : bus0.WB_RF_enable;
    assign wb_out_sel = s_sel ? (bus3.WB_RF_enable | bus3.align_err)
                              : (bus0.WB_RF_enable | bus0.align_err);

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
        logic        en;
        logic        al;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic go_idle();
        s_req  = 1'b0;
        s_load = 1'b0;
        s_size = 1'b0;
        s_rfen = 1'b0;
        s_rd   = 4'hF;
        s_alu  = 32'hA5A5_A5A5;
        s_sd   = 32'h0;
    endtask

    // Present one instruction, follow it through its stall cycles, then
    // check the stall count and whether WB presents a result next cycle.
    task automatic issue(input string name, input logic req, input logic ld,
                         input logic sz, input logic rfen, input logic [3:0] rd,
                         input logic [31:0] a, input logic [31:0] sd,
                         input int unsigned exp_stall, input logic [31:0] exp_data,
                         input logic exp_al);
        int unsigned n;
        logic        done;
        logic        exp_en;
        exp_t        e;
        exp_en = req ? (ld & rfen & ~exp_al) : rfen;
        e = '{rd: rd, data: exp_data, en: exp_en, al: exp_al};
        if (exp_en || exp_al) begin
            if (s_sel) q3.push_back(e);
            else       q0.push_back(e);
        end
        @(posedge clk);
        #1;
        s_req = req; s_load = ld; s_size = sz; s_rfen = rfen;
        s_rd = rd; s_alu = a; s_sd = sd;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (stall_sel) begin
                n++;
                chk({name, " bubble"}, {31'b0, wb_en_sel}, 32'd0);
                @(posedge clk);
                #1;
            end else begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=stalled required=complete", name);
        end
        go_idle();
        chk({name, " stall cycles"}, n, exp_stall);
        @(negedge clk);
        chk({name, " wb presented"}, {31'b0, wb_out_sel}, {31'b0, exp_en | exp_al});
    endtask

    task automatic cmp_wb(input string who, input exp_t e, input logic [3:0] rd,
                          input logic [31:0] data, input logic en, input logic al);
        chk({who, " WB_rd"}, {28'b0, rd}, {28'b0, e.rd});
        chk({who, " WB_data"}, data, e.data);
        chk({who, " WB_RF_enable"}, {31'b0, en}, {31'b0, e.en});
        chk({who, " align_err"}, {31'b0, al}, {31'b0, e.al});
    endtask

    // Monitor for the zero-wait instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus0.WB_RF_enable || bus0.align_err) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut0 unexpected wb actual rd=%h data=%h required=none",
                             bus0.WB_rd, bus0.WB_data);
                end else begin
                    e = q0.pop_front();
                    cmp_wb("dut0", e, bus0.WB_rd, bus0.WB_data, bus0.WB_RF_enable, bus0.align_err);
                end
            end
        end
    end

    // Monitor for the three-wait instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus3.WB_RF_enable || bus3.align_err) begin
                if (q3.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut3 unexpected wb actual rd=%h data=%h required=none",
                             bus3.WB_rd, bus3.WB_data);
                end else begin
                    e = q3.pop_front();
                    cmp_wb("dut3", e, bus3.WB_rd, bus3.WB_data, bus3.WB_RF_enable, bus3.align_err);
                end
            end
        end
    end

    initial begin
        Reset = 1'b1;
        s_sel = 1'b0;
        go_idle();
        #1;
        chk("reset WB_RF_enable", {31'b0, bus0.WB_RF_enable}, 32'd0);
        chk("reset WB_rd", {28'b0, bus0.WB_rd}, 32'd0);
        chk("reset WB_data", bus0.WB_data, 32'd0);
        chk("reset align_err", {31'b0, bus0.align_err}, 32'd0);
        chk("reset mem_stall", {31'b0, bus3.mem_stall}, 32'd0);
        repeat (2) @(negedge clk);
        Reset = 1'b0;

        // Zero wait states: word store/load, pass-through, byte lanes.
        issue("t1 str", 1, 0, 1, 1, 4'd2, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 0);
        issue("t1 ldr", 1, 1, 1, 1, 4'd3, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 0);
        issue("alu pass", 0, 0, 0, 1, 4'd5, 32'h1234_5678, 32'h0, 0, 32'h1234_5678, 0);
        issue("t2 str", 1, 0, 1, 0, 4'd1, 32'h20, 32'h0102_0304, 0, 32'h0, 0);
        issue("t2 strb", 1, 0, 0, 0, 4'd1, 32'h21, 32'h1234_56AB, 0, 32'h0, 0);
        issue("t2 ldrb", 1, 1, 0, 1, 4'd4, 32'h21, 32'h0, 0, 32'h0000_00AB, 0);
        issue("t2 ldr", 1, 1, 1, 1, 4'd6, 32'h20, 32'h0, 0, 32'h01AB_0304, 0);
        issue("upper addr ignored", 1, 1, 0, 1, 4'd2, 32'hFFFF_FF21, 32'h0, 0, 32'h0000_00AB, 0);
`ifndef DMEM_ALIGN_CHECK_EN
        issue("t4 str wrap", 1, 0, 1, 0, 4'd0, 32'hFE, 32'h1122_3344, 0, 32'h0, 0);
        issue("t4 ldrb fe", 1, 1, 0, 1, 4'd1, 32'hFE, 32'h0, 0, 32'h0000_0011, 0);
        issue("t4 ldrb ff", 1, 1, 0, 1, 4'd2, 32'hFF, 32'h0, 0, 32'h0000_0022, 0);
        issue("t4 ldrb 00", 1, 1, 0, 1, 4'd3, 32'h00, 32'h0, 0, 32'h0000_0033, 0);
        issue("t4 ldrb 01", 1, 1, 0, 1, 4'd4, 32'h01, 32'h0, 0, 32'h0000_0044, 0);
        issue("t4 ldr wrap", 1, 1, 1, 1, 4'd5, 32'hFE, 32'h0, 0, 32'h1122_3344, 0);
`else
        issue("t6 str", 1, 0, 1, 0, 4'd0, 32'h10, 32'hCAFE_F00D, 0, 32'h0, 0);
        issue("t6 ldr misaligned", 1, 1, 1, 1, 4'd8, 32'h13, 32'h0, 0, 32'h0, 1);
        @(negedge clk);
        chk("t6 align_err one cycle", {31'b0, bus0.align_err}, 32'd0);
        issue("t6 str misaligned", 1, 0, 1, 0, 4'd9, 32'h13, 32'h9999_9999, 0, 32'h0, 1);
        issue("t6 ldr unchanged", 1, 1, 1, 1, 4'd10, 32'h10, 32'h0, 0, 32'hCAFE_F00D, 0);
`endif

        // Three wait states.
        s_sel = 1'b1;
        issue("t3 str", 1, 0, 1, 0, 4'd0, 32'h30, 32'h5566_7788, 3, 32'h0, 0);
        issue("t3 ldr", 1, 1, 1, 1, 4'd9, 32'h30, 32'h0, 3, 32'h5566_7788, 0);
        issue("t5 strb setup", 1, 0, 0, 0, 4'd0, 32'h40, 32'h0000_005A, 3, 32'h0, 0);

        // Reset in the middle of a store's wait states.
        @(posedge clk);
        #1;
        s_req = 1'b1; s_load = 1'b0; s_size = 1'b0; s_rfen = 1'b0;
        s_rd = 4'hB; s_alu = 32'h40; s_sd = 32'h0000_00C3;
        @(negedge clk);
        chk("t5 stall idle cycle", {31'b0, bus3.mem_stall}, 32'd1);
        @(negedge clk);
        chk("t5 stall wait cycle", {31'b0, bus3.mem_stall}, 32'd1);
        #1;
        Reset = 1'b1;
        #1;
        chk("t5 stall drops", {31'b0, bus3.mem_stall}, 32'd0);
        chk("t5 WB_RF_enable", {31'b0, bus3.WB_RF_enable}, 32'd0);
        chk("t5 WB_rd", {28'b0, bus3.WB_rd}, 32'd0);
        chk("t5 WB_data", bus3.WB_data, 32'd0);
        chk("t5 align_err", {31'b0, bus3.align_err}, 32'd0);
        go_idle();
        @(negedge clk);
        Reset = 1'b0;
        issue("t5 byte unchanged", 1, 1, 0, 1, 4'd7, 32'h40, 32'h0, 3, 32'h0000_005A, 0);

        repeat (2) @(negedge clk);
        chk("dut0 queue drained", q0.size(), 32'd0);
        chk("dut3 queue drained", q3.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
